spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
SPI mode-0 master that drives the board-level SPI bus (SCK, CS_N, MOSI; samples MISO) toward the peripheral's SPI slave port. Bytes are queued over a valid/ready interface. CS_N is held low across a multi-byte burst until a byte tagged last completes, and each received byte is returned as a one-cycle pulse. Used by the bench and by the host-side controller to program the PWM register file over SPI. The block's clock sclk is the master's source clock; the bus clock spi_sck is derived from it.

Parameters:
HALF_DIV, 2, sclk cycles per spi_sck half-period (>=1)
CS_SETUP, 2, sclk cycles from CS_N fall to start of first SCK low phase (>=1)
CS_HOLD, 2, sclk cycles from last SCK fall to CS_N rise (>=1)
CS_GAP, 2, minimum sclk cycles CS_N stays high between transactions (>=1)

Ports:
sclk  input  1  master source clock, all state on posedge
rst_n  input  1  asynchronous, active-low reset
tx_valid  input  1  byte offered for transmission
tx_data  input  8  byte to send, MSB first
tx_last  input  1  qualifies tx_data; release CS_N after this byte
tx_ready  output  1  block accepts tx_data this cycle
rx_valid  output  1  one-cycle pulse, rx_data holds byte just received
rx_data  output  8  received byte, MSB first
busy  output  1  high whenever spi_cs_n is low or in HOLD/GAP
spi_sck  output  1  bus clock, idles low (CPOL=0)
spi_cs_n  output  1  bus chip select, active low
spi_mosi  output  1  bus data out
spi_miso  input  1  bus data in

Behaviour:
- Reset (rst_n=0, async): state IDLE; spi_sck=0, spi_cs_n=1, spi_mosi=0, rx_valid=0, rx_data=0x00, busy=0, tx_ready=1. All outputs are registered except tx_ready, which decodes state.
- States: IDLE, SETUP, LOW, HIGH, NEXT, HOLD, GAP. One down-counter is shared by all states and sized for max(HALF_DIV, CS_SETUP, CS_HOLD, CS_GAP).
- tx_ready=1 only in IDLE and NEXT. Acceptance is the edge where tx_valid&&tx_ready; tx_data/tx_last are latched there.
- IDLE accept (edge T0): spi_cs_n<=0, spi_mosi<=tx_data[7], bit index=7, go SETUP for CS_SETUP cycles, then LOW.
- LOW: spi_sck=0 for HALF_DIV cycles. At the end, spi_sck<=1 and spi_miso is shifted into rx shift register (LSB in) on that same edge; go HIGH.
- HIGH: spi_sck=1 for HALF_DIV cycles. At the end, spi_sck<=0.
  - If bits remain: spi_mosi<=next bit, back to LOW.
  - After the 8th bit: rx_data<=shift register, rx_valid<=1 for exactly one cycle. Go HOLD if the latched last=1, else NEXT.
- NEXT: spi_cs_n stays 0, spi_sck stays 0, spi_mosi holds. Wait indefinitely.
  - On accept at edge T1: spi_mosi<=tx_data[7], go LOW directly (no setup).
- HOLD: CS_HOLD cycles, then spi_cs_n<=1, spi_mosi<=0, go GAP.
- GAP: CS_GAP cycles, then IDLE.
- Latency from IDLE accept T0:
  - first SCK rise at T0+CS_SETUP+HALF_DIV
  - rx_valid at T0+CS_SETUP+16*HALF_DIV
- Latency from NEXT accept T1: rx_valid at T1+16*HALF_DIV.
- Byte period: 16*HALF_DIV sclk cycles. Exactly 8 SCK rising edges per byte, no partial bytes.
- MOSI changes only on SCK falling edges or at CS_N fall; it is stable across every rising edge.
- tx_valid outside IDLE/NEXT is ignored, not queued. tx_valid dropping in NEXT holds the bus idle with CS_N low.
- Reset mid-transfer: bus returns to idle values immediately (CS_N=1, SCK=0). No rx_valid for the partial byte.

Test Plan:
1. HALF_DIV=2, single byte 0xA5 with tx_last=1, slave model returns 0x3C -> MOSI at 8 rising edges reads 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_valid single pulse at T0+34; CS_N rises 2 cycles after the last SCK fall.
2. Burst 0x0B (last=0), then 0x55 (last=1) offered immediately -> CS_N low throughout; second byte's first SCK rise at T1+2; two rx_valid pulses; 16 SCK rises total.
3. Burst with tx_valid withheld 20 cycles in NEXT -> SCK=0, CS_N=0, tx_ready=1, no rx_valid during stall; transfer resumes correctly.
4. Async reset asserted after the 3rd SCK rise -> spi_cs_n=1, spi_sck=0, spi_mosi=0 with no clock edge; the following transaction sends 0x81 correctly.
5. Two single-byte transactions offered back-to-back -> tx_ready=0 through HOLD+GAP; CS_N high for exactly CS_GAP=2 cycles between them.
6. Loopback spi_miso=spi_mosi, bytes 0x00, 0xFF, 0x81 in one burst -> rx_data equals each tx_data in order.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: queued bytes out on MOSI (MSB first), MISO bytes back as rx_valid pulses.
// Latency: rx_valid at accept+CS_SETUP+16*HALF_DIV (first byte), accept+16*HALF_DIV (burst bytes).
// Backpressure: tx_ready only in IDLE/NEXT; CS_N held low in NEXT until the next byte is offered.
module spi_master_ctrl #(
  parameter int HALF_DIV = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int MAX_AB = (HALF_DIV > CS_SETUP) ? HALF_DIV : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] HALF_LD  = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
  // The IDLE cycle before the next accept also has CS_N high, so GAP
  // itself runs one cycle short to make the back-to-back gap exactly CS_GAP.
  localparam logic [CW-1:0] GAP_LD   = CW'((CS_GAP > 1) ? CS_GAP - 2 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, NEXT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          last_q, last_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          busy_q, busy_d;
  logic          accept;
  logic          cnt_zero;

  assign tx_ready = (state_q == IDLE) || (state_q == NEXT);
  assign accept   = tx_valid && tx_ready;
  assign cnt_zero = (cnt_q == '0);

  assign spi_sck  = sck_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;

  // State and bus registers; reset drops the bus to idle immediately.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd7;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: shared down-counter times every phase; MOSI moves only on SCK fall or CS_N fall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cs_n_d  = 1'b0;
          mosi_d  = tx_data[7];
          tx_sh_d = tx_data;
          last_d  = tx_last;
          bit_d   = 3'd7;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          cnt_d   = HALF_LD;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LOW: begin
        if (cnt_zero) begin
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], spi_miso};
          cnt_d   = HALF_LD;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HIGH: begin
        if (cnt_zero) begin
          sck_d = 1'b0;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            mosi_d  = tx_sh_q[bit_q - 3'd1];
            cnt_d   = HALF_LD;
            state_d = LOW;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            if (last_q) begin
              cnt_d   = HOLD_LD;
              state_d = HOLD;
            end else begin
              state_d = NEXT;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      NEXT: begin
        if (accept) begin
          mosi_d  = tx_data[7];
          tx_sh_d = tx_data;
          last_d  = tx_last;
          bit_d   = 3'd7;
          cnt_d   = HALF_LD;
          state_d = LOW;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
          cnt_d  = GAP_LD;
          if (CS_GAP > 1) state_d = GAP;
          else            state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl with default parameters (all timing values 2).
// Expected RX bytes with arrival cycle and expected MOSI bits are queued at stimulus time.
// A negedge monitor pops them as the DUT produces rx_valid pulses and SCK rises.
module tb_spi_master_ctrl;

  logic       sclk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic       mosi_q[$];
  logic [7:0] slv_q[$];

  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  int         rises = 0;
  int         cs_high = 0;
  logic [7:0] miso_byte;
  logic [2:0] miso_idx;
  logic       loopback;

  assign spi_miso = loopback ? spi_mosi : miso_byte[miso_idx];

  spi_master_ctrl dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    forever begin
      @(posedge sclk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish within 30000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: MOSI at each SCK rise, slave MISO shifting, RX scoreboard, CS_N/SCK statistics.
  initial begin
    logic sck_prev;
    logic rxv_prev;
    logic b;
    exp_t e;
    sck_prev = 1'b0;
    rxv_prev = 1'b0;
    forever begin
      @(negedge sclk);
      if (spi_cs_n) cs_high++;
      if (spi_sck && !sck_prev) begin
        rises++;
        if (mosi_q.size() == 0) begin
          check("mosi_unexpected_rise", 32'(1), 32'(0));
        end else begin
          b = mosi_q.pop_front();
          check("mosi_bit", 32'(spi_mosi), 32'(b));
        end
        if (miso_idx == 3'd0) begin
          miso_idx  = 3'd7;
          miso_byte = (slv_q.size() != 0) ? slv_q.pop_front() : 8'h00;
        end else begin
          miso_idx = miso_idx - 3'd1;
        end
      end
      sck_prev = spi_sck;
      if (rx_valid) begin
        check("rx_pulse_width", 32'(rxv_prev), 32'(0));
        if (exp_q.size() == 0) begin
          check("rx_spurious", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.d));
          check("rx_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      rxv_prev = rx_valid;
    end
  end

  task automatic slave_load();
    miso_idx  = 3'd7;
    miso_byte = (slv_q.size() != 0) ? slv_q.pop_front() : 8'h00;
  endtask

  task automatic push_rx(input logic [7:0] d, input int c);
    exp_t e;
    e.d   = d;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns the posedge number that accepted the byte.
  task automatic send(input logic [7:0] d, input logic last, output int t);
    int w;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = last;
    for (int i = 7; i >= 0; i--) mosi_q.push_back(d[i]);
    w = 0;
    while (!tx_ready && w < 100) begin
      @(negedge sclk);
      w++;
    end
    if (!tx_ready) check("tx_accept_timeout", 32'(0), 32'(1));
    t = cyc + 1;
    @(negedge sclk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge sclk);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 400) begin
      @(negedge sclk);
      w++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'(0));
    repeat (2) @(negedge sclk);
  endtask

  initial begin
    int t0;
    int t1;
    int t2;
    int bad;
    rst_n     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_last   = 1'b0;
    loopback  = 1'b0;
    miso_byte = 8'h00;
    miso_idx  = 3'd7;
    repeat (3) @(negedge sclk);
    check("rst_sck", 32'(spi_sck), 32'(0));
    check("rst_cs_n", 32'(spi_cs_n), 32'(1));
    check("rst_mosi", 32'(spi_mosi), 32'(0));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_rx_data", 32'(rx_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    rst_n = 1'b1;
    @(negedge sclk);

    // 1: single byte 0xA5, slave answers 0x3C
    slv_q.delete();
    slv_q.push_back(8'h3C);
    slave_load();
    send(8'hA5, 1'b1, t0);
    push_rx(8'h3C, t0 + 34);
    wait_cyc(t0 + 3);
    check("t1_sck_before_first_rise", 32'(spi_sck), 32'(0));
    wait_cyc(t0 + 4);
    check("t1_first_rise", 32'(spi_sck), 32'(1));
    wait_cyc(t0 + 35);
    check("t1_cs_held", 32'(spi_cs_n), 32'(0));
    check("t1_busy_hold", 32'(busy), 32'(1));
    wait_cyc(t0 + 36);
    check("t1_cs_release", 32'(spi_cs_n), 32'(1));
    check("t1_busy_gap", 32'(busy), 32'(1));
    check("t1_rx_data_kept", 32'(rx_data), 32'(8'h3C));
    wait_idle();

    // 2: burst 0x0B then 0x55 offered immediately
    slv_q.delete();
    slv_q.push_back(8'h12);
    slv_q.push_back(8'h34);
    slave_load();
    rises = 0;
    send(8'h0B, 1'b0, t0);
    push_rx(8'h12, t0 + 34);
    cs_high = 0;
    send(8'h55, 1'b1, t1);
    check("t2_next_accept", 32'(t1 - t0), 32'(35));
    push_rx(8'h34, t1 + 32);
    wait_cyc(t1 + 1);
    check("t2_sck_low_after_next", 32'(spi_sck), 32'(0));
    wait_cyc(t1 + 2);
    check("t2_second_first_rise", 32'(spi_sck), 32'(1));
    wait_cyc(t1 + 32);
    check("t2_rises", 32'(rises), 32'(16));
    check("t2_cs_low_throughout", 32'(cs_high), 32'(0));
    wait_idle();

    // 3: burst with a 20-cycle stall in NEXT
    slv_q.delete();
    slv_q.push_back(8'hA7);
    slv_q.push_back(8'h5A);
    slave_load();
    send(8'hC6, 1'b0, t0);
    push_rx(8'hA7, t0 + 34);
    wait_cyc(t0 + 35);
    bad = 0;
    repeat (20) begin
      if (spi_sck !== 1'b0 || spi_cs_n !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0) bad++;
      @(negedge sclk);
    end
    check("t3_stall_bus_idle", 32'(bad), 32'(0));
    send(8'h39, 1'b1, t1);
    check("t3_resume_accept", 32'(t1 - t0), 32'(56));
    push_rx(8'h5A, t1 + 32);
    wait_idle();

    // 4: async reset after the 3rd SCK rise
    slv_q.delete();
    slv_q.push_back(8'hC3);
    slave_load();
    send(8'hF0, 1'b1, t0);
    wait_cyc(t0 + 12);
    check("t4_third_rise", 32'(spi_sck), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_cs_n", 32'(spi_cs_n), 32'(1));
    check("t4_rst_sck", 32'(spi_sck), 32'(0));
    check("t4_rst_mosi", 32'(spi_mosi), 32'(0));
    check("t4_rst_busy", 32'(busy), 32'(0));
    @(negedge sclk);
    mosi_q.delete();
    slv_q.delete();
    slv_q.push_back(8'h7E);
    slave_load();
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    send(8'h81, 1'b1, t0);
    push_rx(8'h7E, t0 + 34);
    wait_idle();

    // 5: two single-byte transactions back to back
    slv_q.delete();
    slv_q.push_back(8'h11);
    slv_q.push_back(8'h22);
    slave_load();
    send(8'h96, 1'b1, t0);
    push_rx(8'h11, t0 + 34);
    cs_high = 0;
    send(8'h69, 1'b1, t1);
    check("t5_accept_after_hold_gap", 32'(t1 - t0), 32'(38));
    check("t5_cs_gap_cycles", 32'(cs_high), 32'(2));
    push_rx(8'h22, t1 + 34);
    wait_idle();

    // 6: loopback burst 0x00, 0xFF, 0x81
    loopback = 1'b1;
    send(8'h00, 1'b0, t0);
    push_rx(8'h00, t0 + 34);
    send(8'hFF, 1'b0, t1);
    push_rx(8'hFF, t1 + 32);
    send(8'h81, 1'b1, t2);
    push_rx(8'h81, t2 + 32);
    wait_idle();
    loopback = 1'b0;

    repeat (4) @(negedge sclk);
    check("rx_queue_drained", 32'(exp_q.size()), 32'(0));
    check("mosi_queue_drained", 32'(mosi_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
